pim_block_scheduler: RTL
========================

// Module: pim_block_scheduler
// PURPOSE
//  Sequences the BLOCK_NUM peak/blooming blocks of one frame onto PE_NUM shared
//  processing engines inside core_top. On core_start it dispatches block ids
//  0..BLOCK_NUM-1 in order to free engines (round-robin), gated by memory readiness.
//  It tracks per-engine busy state and pulses core_end once every block has completed.
// PARAMETERS
//  BLOCK_NUM   40  blocks per frame; legal range 1..2**ADDR_WIDTH
//  PE_NUM      4   shared processing engines; legal range 1..8
//  ADDR_WIDTH  6   block id / memory row address width
// PORTS
//  clk          in   1           clock
//  rst          in   1           synchronous reset, active-high
//  core_start   in   1           start frame; sampled only in IDLE
//  mem_ready    in   1           block memory can accept a row read this cycle
//  pe_done      in   PE_NUM      per-engine 1-cycle completion pulse
//  mem_rd_en    out  1           row read strobe; coincident with pe_start
//  mem_rd_addr  out  ADDR_WIDTH  row address; equals pe_block_id
//  pe_start     out  PE_NUM      one-hot 1-cycle start pulse to the chosen engine
//  pe_block_id  out  ADDR_WIDTH  block id for the started engine; valid with pe_start
//  pe_busy      out  PE_NUM      registered per-engine busy flags
//  core_busy    out  1           high from DISPATCH entry until DONE exit
//  core_end     out  1           1-cycle completion pulse
//  blk_done_cnt out  ADDR_WIDTH+1 count of completed blocks in the current frame
//  err_spur     out  1           sticky: pe_done seen on an engine that was not busy
// BEHAVIOUR
//  Reset: every output is 0; next_id=0; rr_ptr=0; state=IDLE. A reset mid-frame
//   aborts the frame with no core_end. Engines share rst and abort with it.
//  FSM states: IDLE -> DISPATCH -> DRAIN -> DONE -> IDLE.
//   IDLE:     core_start=1 -> DISPATCH; clear next_id, blk_done_cnt, rr_ptr.
//             err_spur is not cleared here.
//   DISPATCH: issue rule (evaluated every cycle): next_id<BLOCK_NUM AND mem_ready
//             AND some pe_busy[i]==0. Target = first free engine searching from rr_ptr
//             upward, wrapping modulo PE_NUM.
//             On issue at edge t, these appear in cycle t+1 (all registered):
//               pe_start = onehot(target), pe_block_id = next_id, mem_rd_en = 1,
//               mem_rd_addr = next_id, pe_busy[target] = 1.
//             Also on issue: next_id += 1; rr_ptr = (target+1) mod PE_NUM.
//             At most one issue per cycle. When next_id reaches BLOCK_NUM -> DRAIN.
//   DRAIN:    wait until blk_done_cnt==BLOCK_NUM -> DONE.
//   DONE:     core_end=1 for exactly one cycle -> IDLE.
//  Completion: pe_done[i]=1 while pe_busy[i]=1 clears pe_busy[i] at the next edge and
//   increments blk_done_cnt. Multiple done bits in one cycle add their popcount.
//   The engine is eligible for dispatch in the cycle after the clear (no same-cycle
//   reuse).
//  pe_done[i] while pe_busy[i]=0: no count change; err_spur is set (sticky to rst).
//  mem_ready=0: no issue that cycle; state, pointers and busy flags hold; done
//   processing continues normally.
//  All engines busy: dispatch stalls; no pointer change.
//  core_start outside IDLE is ignored. A core_start held high re-launches the next
//   frame the cycle after DONE.
//  core_busy=1 in DISPATCH, DRAIN and DONE.
//  BLOCK_NUM=1: a single issue, then DRAIN.
//  rr_ptr wraps from PE_NUM-1 to 0.
// TESTING (BLOCK_NUM=40, PE_NUM=4, mem_ready=1 unless noted)
//  1 Reset, core_start pulse, engines answer done 5 cycles after start -> ids 0..39
//    each issued exactly once in order; first four go to PE0..PE3; one core_end;
//    blk_done_cnt=40.
//  2 mem_ready toggled every other cycle -> issues occur only in mem_ready=1 cycles;
//    mem_rd_addr==pe_block_id on every strobe; no id skipped or repeated.
//  3 PE2 stalls 200 cycles on its first job -> later ids rotate over PE0, PE1, PE3
//    only; core_end waits for PE2's done.
//  4 pe_done[1] pulsed in IDLE, and again while PE1 is idle mid-frame -> err_spur=1;
//    blk_done_cnt unchanged; frame still ends at 40.
//  5 rst asserted at blk_done_cnt=17 -> next cycle all outputs are 0 and state is
//    IDLE; a new core_start completes a full 40-block frame.
//  6 Two simultaneous done pulses in one cycle, plus core_start held high through
//    DONE -> count advances by 2; the second frame starts one cycle after core_end.

Source files
------------

// File: rtl/pim_block_scheduler.sv
// Frame-level scheduler: dispatches block ids 0..BLOCK_NUM-1 in order onto the first
// free engine (round-robin from rr_ptr), tracks engine busy flags and signals frame end.
module pim_block_scheduler #(
    parameter int BLOCK_NUM  = 40,
    parameter int PE_NUM     = 4,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_start,
    input  logic                  mem_ready,
    input  logic [PE_NUM-1:0]     pe_done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    output logic [PE_NUM-1:0]     pe_start,
    output logic [ADDR_WIDTH-1:0] pe_block_id,
    output logic [PE_NUM-1:0]     pe_busy,
    output logic                  core_busy,
    output logic                  core_end,
    output logic [ADDR_WIDTH:0]   blk_done_cnt,
    output logic                  err_spur
);
    localparam int PTR_W = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_ID = CNT_W'(BLOCK_NUM);

    // The FSM state is a named signal so checkers can bind to it directly.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        DRAIN    = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] next_id;
    logic [PTR_W-1:0] rr_ptr;

    logic [PE_NUM-1:0] done_ok;
    logic [PE_NUM-1:0] done_bad;
    logic [PE_NUM-1:0] start_vec;
    logic [PTR_W-1:0]  target;
    logic [PTR_W-1:0]  rr_next;
    logic              found;
    logic              issue;
    logic [CNT_W-1:0]  done_inc;

    // First free engine at or above rr_ptr, wrapping modulo PE_NUM.
    always_comb begin
        found  = 1'b0;
        target = '0;
        for (int k = 0; k < PE_NUM; k++) begin
            if (!found && !pe_busy[(int'(rr_ptr) + k) % PE_NUM]) begin
                found  = 1'b1;
                target = PTR_W'((int'(rr_ptr) + k) % PE_NUM);
            end
        end
    end

    // Handshake: mem_ready is sampled at the decision edge; a row read is committed
    // only at an edge where mem_ready=1, and mem_rd_en/pe_start show it one cycle later.
    always_comb begin
        issue     = (state == DISPATCH) && (next_id < LAST_ID) && mem_ready && found;
        start_vec = '0;
        if (issue) begin
            start_vec[target] = 1'b1;
        end
        rr_next  = (int'(target) == PE_NUM - 1) ? '0 : target + 1'b1;
        done_ok  = pe_done & pe_busy;
        done_bad = pe_done & ~pe_busy;
        done_inc = CNT_W'($countones(done_ok));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            next_id      <= '0;
            rr_ptr       <= '0;
            mem_rd_en    <= 1'b0;
            mem_rd_addr  <= '0;
            pe_start     <= '0;
            pe_block_id  <= '0;
            pe_busy      <= '0;
            core_busy    <= 1'b0;
            core_end     <= 1'b0;
            blk_done_cnt <= '0;
            err_spur     <= 1'b0;
        end else begin
            pe_start     <= start_vec;
            mem_rd_en    <= issue;
            pe_block_id  <= issue ? next_id[ADDR_WIDTH-1:0] : '0;
            mem_rd_addr  <= issue ? next_id[ADDR_WIDTH-1:0] : '0;
            pe_busy      <= (pe_busy & ~done_ok) | start_vec;
            blk_done_cnt <= blk_done_cnt + done_inc;
            core_end     <= 1'b0;
            if (|done_bad) begin
                err_spur <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (core_start) begin
                        state        <= DISPATCH;
                        next_id      <= '0;
                        rr_ptr       <= '0;
                        blk_done_cnt <= '0;
                        core_busy    <= 1'b1;
                    end
                end
                DISPATCH: begin
                    if (issue) begin
                        next_id <= next_id + 1'b1;
                        rr_ptr  <= rr_next;
                        if (next_id + 1'b1 == LAST_ID) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (blk_done_cnt == LAST_ID) begin
                        state    <= DONE;
                        core_end <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    core_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
